// File: rtl/batcharger_controller_gen2_if.sv
// Interface between the ADC/OTP side and the charge controller.
// The master drives enables, samples and thresholds; the slave returns mode selects and status.
interface batcharger_controller_gen2_if #(
    parameter int DW = 8,
    parameter int TW = 8
);
    logic          en;
    logic          vtok;
    logic [DW-1:0] vbat;
    logic [DW-1:0] ibat;
    logic [DW-1:0] tbat;
    logic [DW-1:0] vcutoff;
    logic [DW-1:0] vpreset;
    logic [DW-1:0] iend;
    logic [DW-1:0] tempmin;
    logic [DW-1:0] tempmax;
    logic [TW-1:0] tmax;
    logic          tc;
    logic          cc;
    logic          cv;
    logic          imonen;
    logic          vmonen;
    logic          tmonen;
    logic          done;
    logic          fault;
    logic [2:0]    state;

    modport master (
        output en, vtok, vbat, ibat, tbat, vcutoff, vpreset, iend, tempmin, tempmax, tmax,
        input  tc, cc, cv, imonen, vmonen, tmonen, done, fault, state
    );

    modport slave (
        input  en, vtok, vbat, ibat, tbat, vcutoff, vpreset, iend, tempmin, tempmax, tmax,
        output tc, cc, cv, imonen, vmonen, tmonen, done, fault, state
    );
endinterface

// File: rtl/batcharger_controller_gen2.sv
// Li-ion charge controller FSM with debounced transitions, temperature fault, recharge and session timer.
// Define BATCHARGER_FAULT_LATCH_EN to latch FAULT until en=0 or rst (no temperature recovery).
module batcharger_controller_gen2 #(
    parameter int DW    = 8,
    parameter int TW    = 8,
    parameter int TUNIT = 255,
    parameter int DEB   = 4,
    parameter int RHYST = 8,
    parameter int THYST = 4
) (
    input logic                         clk,
    input logic                         rst,
    batcharger_controller_gen2_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_TC    = 3'd2;
    localparam logic [2:0] S_CC    = 3'd3;
    localparam logic [2:0] S_CV    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int PW = (TUNIT > 1) ? $clog2(TUNIT) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TUNIT - 1);
    localparam logic [DW:0]   RHYST_V   = (DW + 1)'(RHYST);
    localparam logic [DW:0]   THYST_V   = (DW + 1)'(THYST);

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + b;
        return s[DW] ? {DW{1'b1}} : s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW:0] b);
        logic [DW:0] d;
        d = {1'b0, a} - b;
        return ({1'b0, a} >= b) ? d[DW-1:0] : {DW{1'b0}};
    endfunction

    function automatic logic [CW-1:0] deb_step(input logic [CW-1:0] cnt, input logic active);
        if (!active)
            return {CW{1'b0}};
        return (cnt == DEB_LAST) ? cnt : cnt + 1'b1;
    endfunction

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] deb_a;
    logic [CW-1:0] deb_b;
    logic [CW-1:0] deb_t;
    logic [PW-1:0] pre;
    logic [TW-1:0] ucnt;
    logic [TW-1:0] ucnt_inc;
    logic          tc_r, cc_r, cv_r, mon_r, done_r, fault_r;

    logic          tempok;
    logic          rec_ok;
    logic [DW-1:0] rch_thr;
    logic          cond_a, cond_b, cond_t;
    logic          hit_a, hit_b, hit_t;
    logic          temp_zone, run, pre_wrap, timeout, changed;

    assign tempok  = (bus.tbat >= bus.tempmin) && (bus.tbat <= bus.tempmax);
    assign rch_thr = sat_sub(bus.vpreset, RHYST_V);

`ifdef BATCHARGER_FAULT_LATCH_EN
    assign rec_ok = 1'b0;
`else
    logic [DW-1:0] rec_lo;
    logic [DW-1:0] rec_hi;
    assign rec_lo = sat_add(bus.tempmin, THYST_V);
    assign rec_hi = sat_sub(bus.tempmax, THYST_V);
    assign rec_ok = (bus.tbat >= rec_lo) && (bus.tbat <= rec_hi);
`endif

    assign temp_zone = (state == S_WAIT) || (state == S_TC) || (state == S_CC) ||
                       (state == S_CV) || (state == S_DONE);
    assign run       = (state == S_TC) || (state == S_CC) || (state == S_CV);
    assign cond_t    = temp_zone && !tempok;

    // cond_a is the primary exit of the current state; cond_b is the CV fallback to CC
    always_comb begin
        cond_a = 1'b0;
        cond_b = 1'b0;
        case (state)
            S_TC:    cond_a = bus.vbat >= bus.vcutoff;
            S_CC:    cond_a = bus.vbat >= bus.vpreset;
            S_CV: begin
                cond_a = bus.ibat < bus.iend;
                cond_b = bus.vbat < bus.vpreset;
            end
            S_DONE:  cond_a = bus.vbat < rch_thr;
            S_FAULT: cond_a = rec_ok;
            default: ;
        endcase
    end

    assign hit_a = bus.vtok && cond_a && (deb_a == DEB_LAST);
    assign hit_b = bus.vtok && cond_b && (deb_b == DEB_LAST);
    assign hit_t = bus.vtok && cond_t && (deb_t == DEB_LAST);

    // Timeout fires on the edge the unit counter reaches tmax, so a session lasts tmax*TUNIT cycles
    assign ucnt_inc = (ucnt == {TW{1'b1}}) ? ucnt : ucnt + 1'b1;
    assign pre_wrap = (pre == PRE_LAST);
    assign timeout  = run && (bus.tmax != {TW{1'b0}}) &&
                      ((ucnt == bus.tmax) || (pre_wrap && (ucnt_inc == bus.tmax)));

    always_comb begin
        state_nxt = state;
        if (!bus.en) begin
            state_nxt = S_IDLE;
        end else if (hit_t) begin
            state_nxt = S_FAULT;
        end else if (timeout) begin
            state_nxt = S_DONE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_WAIT;
                S_WAIT: begin
                    if (bus.vtok && tempok) begin
                        if (bus.vbat < bus.vcutoff)
                            state_nxt = S_TC;
                        else if (bus.vbat < bus.vpreset)
                            state_nxt = S_CC;
                        else
                            state_nxt = S_CV;
                    end
                end
                S_TC:    if (hit_a) state_nxt = S_CC;
                S_CC:    if (hit_a) state_nxt = S_CV;
                S_CV: begin
                    if (hit_a)
                        state_nxt = S_DONE;
                    else if (hit_b)
                        state_nxt = S_CC;
                end
                S_DONE:  if (hit_a) state_nxt = S_WAIT;
                S_FAULT: if (hit_a) state_nxt = S_WAIT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign changed = (state_nxt != state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            deb_a   <= '0;
            deb_b   <= '0;
            deb_t   <= '0;
            pre     <= '0;
            ucnt    <= '0;
            tc_r    <= 1'b0;
            cc_r    <= 1'b0;
            cv_r    <= 1'b0;
            mon_r   <= 1'b0;
            done_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state <= state_nxt;
            deb_a <= deb_step(deb_a, bus.vtok && cond_a && !changed);
            deb_b <= deb_step(deb_b, bus.vtok && cond_b && !changed);
            deb_t <= deb_step(deb_t, bus.vtok && cond_t && !changed);
            if (state_nxt == S_WAIT) begin
                pre  <= '0;
                ucnt <= '0;
            end else if (run) begin
                pre <= pre_wrap ? '0 : pre + 1'b1;
                if (pre_wrap)
                    ucnt <= ucnt_inc;
            end
            // Outputs decode the next state so they line up with the state register
            tc_r    <= (state_nxt == S_TC);
            cc_r    <= (state_nxt == S_CC);
            cv_r    <= (state_nxt == S_CV);
            mon_r   <= (state_nxt != S_IDLE);
            done_r  <= (state_nxt == S_DONE);
            fault_r <= (state_nxt == S_FAULT);
        end
    end

    assign bus.tc     = tc_r;
    assign bus.cc     = cc_r;
    assign bus.cv     = cv_r;
    assign bus.imonen = mon_r;
    assign bus.vmonen = mon_r;
    assign bus.tmonen = mon_r;
    assign bus.done   = done_r;
    assign bus.fault  = fault_r;
    assign bus.state  = state;
endmodule

// File: tb/tb_batcharger_controller_gen2.sv
// Directed bench for batcharger_controller_gen2 with hand-computed states and output vectors.
// Output vector layout: {tc, cc, cv, imonen, vmonen, tmonen, done, fault}.
module tb_batcharger_controller_gen2;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_TC    = 3'd2;
    localparam logic [2:0] S_CC    = 3'd3;
    localparam logic [2:0] S_CV    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    localparam logic [7:0] O_IDLE  = 8'h00;
    localparam logic [7:0] O_WAIT  = 8'h1C;
    localparam logic [7:0] O_TC    = 8'h9C;
    localparam logic [7:0] O_CC    = 8'h5C;
    localparam logic [7:0] O_CV    = 8'h3C;
    localparam logic [7:0] O_DONE  = 8'h1E;
    localparam logic [7:0] O_FAULT = 8'h1D;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    batcharger_controller_gen2_if #(.DW(8), .TW(8)) bus ();

    batcharger_controller_gen2 #(
        .DW(8), .TW(8), .TUNIT(16), .DEB(4), .RHYST(8), .THYST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] outs;
    assign outs = {bus.tc, bus.cc, bus.cv, bus.imonen, bus.vmonen, bus.tmonen, bus.done, bus.fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_st(input string tag, input logic [2:0] st, input logic [7:0] ov);
        check({tag, "_state"}, {29'd0, bus.state}, {29'd0, st});
        check({tag, "_outs"}, {24'd0, outs}, {24'd0, ov});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.vtok    = 1'b0;
        bus.vbat    = 8'h99;
        bus.ibat    = 8'h80;
        bus.tbat    = 8'h64;
        bus.vcutoff = 8'hA3;
        bus.vpreset = 8'hC7;
        bus.iend    = 8'h33;
        bus.tempmin = 8'h2E;
        bus.tempmax = 8'h8B;
        bus.tmax    = 8'd0;
        tick(2);
        check_st("reset", S_IDLE, O_IDLE);

        // Startup: WAIT at edge 1, TC at edge 2
        rst      = 1'b0;
        bus.en   = 1'b1;
        bus.vtok = 1'b1;
        tick(1);
        check_st("start_wait", S_WAIT, O_WAIT);
        tick(1);
        check_st("start_tc", S_TC, O_TC);

        // Three-cycle glitch above vcutoff must not move TC
        bus.vbat = 8'hA4;
        tick(3);
        check("glitch_3", {29'd0, bus.state}, {29'd0, S_TC});
        bus.vbat = 8'h99;
        tick(1);
        check("glitch_clear", {29'd0, bus.state}, {29'd0, S_TC});
        bus.vbat = 8'hA4;
        tick(3);
        check("tc_edge3", {29'd0, bus.state}, {29'd0, S_TC});
        tick(1);
        check_st("tc_to_cc", S_CC, O_CC);

        // vtok low blocks the CC->CV transition
        bus.vbat = 8'hC8;
        bus.vtok = 1'b0;
        tick(10);
        check("vtok_low_hold", {29'd0, bus.state}, {29'd0, S_CC});
        bus.vtok = 1'b1;
        tick(3);
        check("cc_edge3", {29'd0, bus.state}, {29'd0, S_CC});
        tick(1);
        check_st("cc_to_cv", S_CV, O_CV);

        bus.ibat = 8'h32;
        tick(3);
        check("cv_edge3", {29'd0, bus.state}, {29'd0, S_CV});
        tick(1);
        check_st("cv_to_done", S_DONE, O_DONE);

        // Recharge threshold is 0xC7-8 = 0xBF: 0xBF holds DONE, 0xBE recharges
        bus.ibat = 8'h80;
        bus.vbat = 8'hBF;
        tick(6);
        check("done_hold_bf", {29'd0, bus.state}, {29'd0, S_DONE});
        bus.vbat = 8'hBE;
        tick(3);
        check("done_edge3", {29'd0, bus.state}, {29'd0, S_DONE});
        tick(1);
        check_st("recharge_wait", S_WAIT, O_WAIT);
        tick(1);
        check_st("recharge_cc", S_CC, O_CC);

        // CV with both exits debounced together: DONE wins
        bus.vbat = 8'hC8;
        tick(4);
        check("cc_to_cv_2", {29'd0, bus.state}, {29'd0, S_CV});
        bus.vbat = 8'hC6;
        bus.ibat = 8'h32;
        tick(4);
        check_st("cv_both_done", S_DONE, O_DONE);

        // en=0 mid-CV drops to IDLE on the next edge
        bus.en = 1'b0;
        tick(1);
        bus.en   = 1'b1;
        bus.vbat = 8'hC8;
        bus.ibat = 8'h80;
        tick(2);
        check("restart_cv", {29'd0, bus.state}, {29'd0, S_CV});
        bus.en = 1'b0;
        tick(1);
        check_st("en_low_idle", S_IDLE, O_IDLE);

        // Temperature fault from CC
        bus.en   = 1'b1;
        bus.vbat = 8'hB0;
        tick(2);
        check("fault_pre_cc", {29'd0, bus.state}, {29'd0, S_CC});
        bus.tbat = 8'h8C;
        tick(3);
        check("fault_edge3", {29'd0, bus.state}, {29'd0, S_CC});
        tick(1);
        check_st("fault_enter", S_FAULT, O_FAULT);
`ifdef BATCHARGER_FAULT_LATCH_EN
        bus.tbat = 8'h64;
        tick(8);
        check("fault_latched", {29'd0, bus.state}, {29'd0, S_FAULT});
        bus.en = 1'b0;
        tick(1);
        check_st("fault_en_low", S_IDLE, O_IDLE);
        bus.en = 1'b1;
        tick(1);
`else
        // Recovery window is 0x32..0x87
        bus.tbat = 8'h88;
        tick(6);
        check("fault_hold_88", {29'd0, bus.state}, {29'd0, S_FAULT});
        bus.tbat = 8'h87;
        tick(3);
        check("fault_edge3_87", {29'd0, bus.state}, {29'd0, S_FAULT});
        tick(1);
        check_st("fault_recover", S_WAIT, O_WAIT);
        tick(1);
        check("fault_recover_cc", {29'd0, bus.state}, {29'd0, S_CC});
`endif

        // Session timeout: TC lasts exactly 8*16 = 128 edges after leaving WAIT
        bus.en   = 1'b0;
        bus.tbat = 8'h64;
        bus.vbat = 8'h99;
        bus.tmax = 8'd8;
        tick(1);
        bus.en = 1'b1;
        tick(1);
        check("to_wait", {29'd0, bus.state}, {29'd0, S_WAIT});
        tick(1);
        check("to_tc", {29'd0, bus.state}, {29'd0, S_TC});
        tick(127);
        check("to_edge127", {29'd0, bus.state}, {29'd0, S_TC});
        tick(1);
        check_st("to_done", S_DONE, O_DONE);

        // tmax=0 disables the timeout
        bus.tmax = 8'd0;
        bus.en   = 1'b0;
        tick(1);
        bus.en = 1'b1;
        tick(2);
        check("notimeout_tc", {29'd0, bus.state}, {29'd0, S_TC});
        tick(1100);
        check_st("notimeout_hold", S_TC, O_TC);

        // Asynchronous reset mid-TC clears outputs without waiting for a clock edge
        rst = 1'b1;
        #1;
        check_st("async_rst", S_IDLE, O_IDLE);
        rst = 1'b0;
        tick(1);
        check("after_rst_wait", {29'd0, bus.state}, {29'd0, S_WAIT});
        tick(1);
        check_st("after_rst_tc", S_TC, O_TC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/batcharger_controller_gen2.md
Name: batcharger_controller_gen2

Overview:
- Second-generation Li-ion charge controller FSM, parametrised in ADC width, timer resolution and debounce depth.
- Drives the analog charger mode selects (tc/cc/cv) and the monitor enables, sitting between the ADC/OTP interface and the charger analog block.
- Adds the following over the first generation:
  - debounced transitions;
  - a temperature FAULT state with hysteresis;
  - an end-of-charge DONE state with automatic recharge;
  - a session timer with a programmable unit.

Parameters:
- DW, 8, width of all ADC samples and OTP thresholds
- TW, 8, width of tmax
- TUNIT, 255, clock cycles per tmax unit
- DEB, 4, consecutive valid samples required before any condition-driven transition (min 1)
- RHYST, 8, recharge hysteresis in vbat LSBs below vpreset
- THYST, 4, temperature recovery hysteresis in tbat LSBs

Ports:
- clk  in  1  state machine clock
- rst  in  1  asynchronous active-high reset
- en  in  1  controller enable
- vtok  in  1  vbat/ibat/tbat samples valid
- vbat  in  DW  battery voltage code
- ibat  in  DW  battery current code
- tbat  in  DW  battery temperature code
- vcutoff  in  DW  trickle-exit threshold
- vpreset  in  DW  CV threshold
- iend  in  DW  end-of-charge current
- tempmin  in  DW  minimum temperature code
- tempmax  in  DW  maximum temperature code
- tmax  in  TW  session time limit in TUNIT units; 0 disables timeout
- tc  out  1  trickle mode
- cc  out  1  constant-current mode
- cv  out  1  constant-voltage mode
- imonen  out  1  current monitor enable
- vmonen  out  1  voltage monitor enable
- tmonen  out  1  temperature monitor enable
- done  out  1  charge complete
- fault  out  1  temperature fault
- state  out  3  state code: IDLE=0, WAIT=1, TC=2, CC=3, CV=4, DONE=5, FAULT=6

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; timer and debounce counters 0.
- All outputs are registered and decoded from state:
  - tc in TC, cc in CC, cv in CV, done in DONE, fault in FAULT;
  - imonen = vmonen = tmonen = 1 in every state except IDLE.
- All compares are unsigned. tempok = tempmin <= tbat <= tempmax.
- Debounce: "cond debounced" means cond true with vtok=1 on DEB consecutive clock edges.
  - The state changes at the DEB-th such edge.
  - The counter clears when cond is false, when vtok=0, or on any state change.
  - A separate counter debounces temperature fault.
- Transition priority, evaluated every edge: en=0 > temperature fault > timeout > normal transitions.
  - en=0 in any state: IDLE next edge.
  - Not tempok, debounced, in WAIT/TC/CC/CV/DONE: FAULT.
  - Timeout in TC/CC/CV: DONE.
- Normal transitions:
  - IDLE: en=1 -> WAIT.
  - WAIT, on first edge with vtok=1 and tempok (no debounce): vbat<vcutoff -> TC; else vbat<vpreset -> CC; else CV.
  - TC: vbat>=vcutoff debounced -> CC.
  - CC: vbat>=vpreset debounced -> CV.
  - CV: ibat<iend debounced -> DONE; else vbat<vpreset debounced -> CC. If both complete on the same edge, DONE wins.
  - DONE: vbat < sat0(vpreset-RHYST) debounced -> WAIT. If vpreset<RHYST, the threshold is 0 and recharge never occurs.
  - FAULT: tempmin+THYST <= tbat <= tempmax-THYST debounced -> WAIT.
    - Sums saturate at 2^DW-1 and differences saturate at 0.
    - If the window is empty, recovery never occurs.
- Session timer:
  - A prescaler counts 0..TUNIT-1. At wrap, the unit counter increments, saturating at 2^TW-1.
  - Both clear on entry to WAIT and run in TC/CC/CV only.
  - Timeout occurs when tmax!=0 and the unit counter equals tmax.
- vtok=0: no condition-driven transition, and debounce counters clear. The timer keeps running and the en/timeout paths stay active.
- Reset asserted mid-charge: immediate IDLE with outputs low. After deassert, en=1 restarts via WAIT.

Optional Feature:
- Macro: BATCHARGER_FAULT_LATCH_EN.
- Defined: FAULT is latched and the temperature recovery path is removed. The only exits are en=0 or rst.
- Undefined: FAULT auto-recovers to WAIT through the THYST window as described above.

Test Plan:
Defaults unless noted (DW=8, DEB=4, TUNIT=16, tmax=8, iend=0x33, RHYST=8, THYST=4); vcutoff=0xA3, vpreset=0xC7, tempmin=0x2E, tempmax=0x8B, tbat=0x64.
- vbat=0x99, en=1, vtok=1 after rst -> WAIT at edge 1, TC at edge 2. At vbat=0xA4, cc=1 on the 4th valid edge; a 3-cycle pulse to 0xA4 causes no transition.
- In CC, vbat=0xC8 -> CV after 4 edges. Then ibat=0x32 -> DONE (done=1, cv=0) after 4 edges. Then vbat=0xBE -> WAIT -> CC.
- In CV, vbat=0xC6 and ibat=0x32 from the same edge -> DONE, not CC.
- Hold vbat=0x99 in TC -> DONE exactly 8*16=128 edges after WAIT. With tmax=0, TC persists for more than 1000 cycles.
- tbat=0x8C in CC -> FAULT after 4 edges, tc=cc=cv=0.
  - Without macro: tbat=0x88 stays in FAULT; tbat=0x87 -> WAIT after 4 edges.
  - With macro: FAULT held until en=0 -> IDLE.
- vtok=0 for 10 cycles while vbat>=vpreset in CC -> no transition. en=0 mid-CV -> IDLE next edge with all outputs 0. rst pulse mid-TC -> outputs 0 immediately.
